// File: rtl/sync_fifo_pkg.sv
// Shared types and default widths for the sync_fifo family.
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } buf_state_e;

  localparam int unsigned DefWi      = 8;
  localparam int unsigned DefCntBits = 5;
  localparam int unsigned DefPktBits = 16;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry output buffer: registered main stage plus one skid register, strict FIFO order.
module stream_skid_buf
  import sync_fifo_pkg::*;
#(
  parameter int unsigned Width = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             accept,
  input  logic [Width-1:0] in_payload,
  output logic [Width-1:0] out_payload,
  output logic             out_valid,
  output buf_state_e       state
);

  buf_state_e       state_q, state_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             valid_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (clear) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            main_d  = in_payload;
            state_d = StOne;
          end
        end
        StOne: begin
          if (push && accept) begin
            main_d = in_payload;
          end else if (push) begin
            skid_d  = in_payload;
            state_d = StTwo;
          end else if (accept) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          // Pops are blocked in this state, so only the skid word can advance.
          if (accept) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= (state_d != StEmpty);
    end
  end

  assign out_payload = main_q;
  assign out_valid   = valid_q;
  assign state       = state_q;

endmodule

// File: rtl/sync_fifo_drain.sv
// Drains a FWFT FIFO into a valid/ready stream framed into PKT_LEN-word packets.
// Optional out_parity port when SYNC_FIFO_DRAIN_PARITY_EN is defined.
module sync_fifo_drain
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WI      = DefWi,
  parameter int unsigned PKT_LEN = 16,
  parameter int unsigned CNTBITS = DefCntBits,
  parameter int unsigned PKTBITS = DefPktBits
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [WI-1:0]      fifo_rdata,
  input  logic               fifo_empty,
  output logic               fifo_read,
  output logic [WI-1:0]      out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic [PKTBITS-1:0] pkt_count
`ifdef SYNC_FIFO_DRAIN_PARITY_EN
  ,
  output logic               out_parity
`endif
);

`ifdef SYNC_FIFO_DRAIN_PARITY_EN
  localparam int unsigned PayW = WI + 2;
`else
  localparam int unsigned PayW = WI + 1;
`endif

  localparam logic [CNTBITS-1:0] LastIdx = CNTBITS'(PKT_LEN - 1);
  localparam logic [CNTBITS-1:0] PenIdx  = CNTBITS'(PKT_LEN - 2);

  buf_state_e         buf_state;
  logic               push, accept, in_last;
  logic [PayW-1:0]    in_payload, main_payload;
  logic [CNTBITS-1:0] wcnt_q, wcnt_d;
  logic [PKTBITS-1:0] pkt_q, pkt_d;

  assign push      = enable & ~clear & ~fifo_empty & (buf_state != StTwo) & ~reset;
  assign accept    = out_valid & out_ready & enable & ~clear;
  assign fifo_read = push;

  // A pushed word sits behind the main word whenever the buffer is not empty.
  assign in_last = (buf_state == StEmpty) ? (wcnt_q == LastIdx) : (wcnt_q == PenIdx);

`ifdef SYNC_FIFO_DRAIN_PARITY_EN
  assign in_payload = {^fifo_rdata, in_last, fifo_rdata};
  assign out_parity = main_payload[WI+1];
`else
  assign in_payload = {in_last, fifo_rdata};
`endif

  stream_skid_buf #(
    .Width(PayW)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .push       (push),
    .accept     (accept),
    .in_payload (in_payload),
    .out_payload(main_payload),
    .out_valid  (out_valid),
    .state      (buf_state)
  );

  assign out_data = main_payload[WI-1:0];
  assign out_last = main_payload[WI];

  always_comb begin
    wcnt_d = wcnt_q;
    pkt_d  = pkt_q;
    if (clear) begin
      wcnt_d = '0;
      pkt_d  = '0;
    end else if (accept) begin
      if (wcnt_q == LastIdx) begin
        wcnt_d = '0;
        pkt_d  = pkt_q + PKTBITS'(1);
      end else begin
        wcnt_d = wcnt_q + CNTBITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q <= '0;
      pkt_q  <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      pkt_q  <= pkt_d;
    end
  end

  assign pkt_count = pkt_q;

endmodule

// File: tb/tb_sync_fifo_drain.sv
// Directed self-checking bench for sync_fifo_drain with a behavioural FWFT FIFO.
module tb_sync_fifo_drain;

  logic        clk = 1'b0;
  logic        reset, enable, clear, out_ready;
  logic [7:0]  fifo_rdata;
  logic        fifo_empty, fifo_read;
  logic [7:0]  out_data;
  logic        out_valid, out_last;
  logic [15:0] pkt_count;
`ifdef SYNC_FIFO_DRAIN_PARITY_EN
  logic        out_parity;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int acc_words = 0;

  logic [7:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_rdata = mem[rd_ptr[11:0]];

  always @(posedge clk) begin
    if (fifo_read) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  sync_fifo_drain dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .clear     (clear),
    .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty),
    .fifo_read (fifo_read),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .pkt_count (pkt_count)
`ifdef SYNC_FIFO_DRAIN_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  task automatic push_word(input logic [7:0] d);
    mem[wr_ptr[11:0]] = d;
    wr_ptr++;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; clear = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(8'(i));
    repeat (2) @(negedge clk);
    n_chk++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_read: got %b want 0", fifo_read); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_chk++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b want 0", out_last); end
    n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", out_data); end
    n_chk++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL rst_pkt: got %0d want 0", pkt_count); end
    reset = 1'b0;
    #1;
    n_chk++; if (fifo_read !== 1'b1) begin n_fail++; $display("FAIL first_pop: got %b want 1", fifo_read); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== 8'(i) || out_last !== (i == 15)) begin
        n_fail++;
        $display("FAIL pkt0_word%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, out_valid, out_data, out_last, 8'(i), (i == 15));
      end
      acc_words++;
    end
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pkt0_drained: got %b want 0", out_valid); end
    n_chk++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL pkt0_count: got %0d want 1", pkt_count); end
  endtask

  task automatic test_backpressure;
    int p0, got;
    logic [7:0] exp;
    out_ready = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) push_word(8'h20 + 8'(i));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== 8'h20) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=20", k, out_valid, out_data);
      end
    end
    n_chk++; if (pop_cnt - p0 != 2) begin n_fail++; $display("FAIL bp_pops: got %0d want 2", pop_cnt - p0); end
    n_chk++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL bp_read: got %b want 0", fifo_read); end
    out_ready = 1'b1;
    exp = 8'h20; got = 0;
    for (int c = 0; c < 30 && got < 8; c++) begin
      if (out_valid) begin
        n_chk++;
        if (out_data !== exp || out_last !== 1'b0) begin
          n_fail++; $display("FAIL bp_seq: got d=%h l=%b want d=%h l=0", out_data, out_last, exp);
        end
        exp++; got++; acc_words++;
      end
      @(negedge clk);
    end
    n_chk++; if (got != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", got); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup: got valid %b want 0", out_valid); end
  endtask

  task automatic test_random_ready;
    int sent, got;
    logic [7:0] exp;
    sent = 0; got = 0; exp = 8'h40;
    for (int c = 0; c < 3000 && got < 64; c++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 64 && $urandom_range(0, 9) < 7) begin
        push_word(8'h40 + 8'(sent));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (out_data !== exp || out_last !== ((acc_words % 16) == 15)) begin
          n_fail++;
          $display("FAIL rnd_word: got d=%h l=%b want d=%h l=%b",
                   out_data, out_last, exp, ((acc_words % 16) == 15));
        end
        exp++; got++; acc_words++;
      end
    end
    n_chk++; if (got != 64) begin n_fail++; $display("FAIL rnd_count: got %0d want 64", got); end
    @(negedge clk);
    out_ready = 1'b1;
    n_chk++;
    if (pkt_count !== 16'(acc_words / 16)) begin
      n_fail++; $display("FAIL rnd_pkt: got %0d want %0d", pkt_count, acc_words / 16);
    end
  endtask

  task automatic test_clear;
    int p0, got;
    logic [7:0] exp;
    out_ready = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    acc_words = 0;
    n_chk++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL clr0_pkt: got %0d want 0", pkt_count); end
    for (int i = 0; i < 7; i++) push_word(8'h80 + 8'(i));
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 7; c++) begin
      @(negedge clk);
      if (out_valid) begin got++; acc_words++; end
    end
    @(negedge clk);
    out_ready = 1'b0;
    push_word(8'h90); push_word(8'h91); push_word(8'h92);
    repeat (3) @(negedge clk);
    n_chk++;
    if (out_data !== 8'h90 || fifo_read !== 1'b0) begin
      n_fail++; $display("FAIL clr_two: got d=%h rd=%b want d=90 rd=0", out_data, fifo_read);
    end
    clear = 1'b1; out_ready = 1'b1;
    p0 = pop_cnt;
    #1;
    n_chk++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL clr_read: got %b want 0", fifo_read); end
    @(negedge clk);
    clear = 1'b0;
    acc_words = 0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", out_valid); end
    n_chk++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL clr_pkt: got %0d want 0", pkt_count); end
    n_chk++; if (pop_cnt != p0) begin n_fail++; $display("FAIL clr_pops: got %0d want 0", pop_cnt - p0); end
    for (int i = 0; i < 15; i++) push_word(8'h93 + 8'(i));
    exp = 8'h92; got = 0;
    for (int c = 0; c < 40 && got < 16; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_chk++;
        if (out_data !== exp || out_last !== (got == 15)) begin
          n_fail++; $display("FAIL clr_pkt_word%0d: got d=%h l=%b want d=%h l=%b",
                             got, out_data, out_last, exp, (got == 15));
        end
        exp++; got++; acc_words++;
      end
    end
    n_chk++; if (got != 16) begin n_fail++; $display("FAIL clr_pkt_len: got %0d want 16", got); end
    @(negedge clk);
    n_chk++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL clr_pkt_done: got %0d want 1", pkt_count); end
  endtask

  task automatic test_enable;
    int p0, got;
    logic [7:0] exp;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'hB0 + 8'(i));
    repeat (3) @(negedge clk);
    enable = 1'b0; out_ready = 1'b1;
    p0 = pop_cnt;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++;
      if (fifo_read !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hB0) begin
        n_fail++; $display("FAIL en_hold%0d: got rd=%b v=%b d=%h want rd=0 v=1 d=b0",
                           k, fifo_read, out_valid, out_data);
      end
    end
    n_chk++; if (pop_cnt != p0) begin n_fail++; $display("FAIL en_pops: got %0d want 0", pop_cnt - p0); end
    enable = 1'b1;
    exp = 8'hB0; got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (out_valid) begin
        n_chk++;
        if (out_data !== exp) begin
          n_fail++; $display("FAIL en_seq: got %h want %h", out_data, exp);
        end
        exp++; got++; acc_words++;
      end
      @(negedge clk);
    end
    n_chk++; if (got != 4) begin n_fail++; $display("FAIL en_count: got %0d want 4", got); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL en_dup: got valid %b want 0", out_valid); end
    n_chk++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL en_pkt: got %0d want 1", pkt_count); end
  endtask

`ifdef SYNC_FIFO_DRAIN_PARITY_EN
  task automatic test_parity;
    out_ready = 1'b0;
    push_word(8'h07); push_word(8'h03);
    repeat (3) @(negedge clk);
    n_chk++;
    if (out_data !== 8'h07 || out_parity !== 1'b1) begin
      n_fail++; $display("FAIL par_07: got d=%h p=%b want d=07 p=1", out_data, out_parity);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (out_data !== 8'h03 || out_parity !== 1'b0) begin
      n_fail++; $display("FAIL par_03: got d=%h p=%b want d=03 p=0", out_data, out_parity);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    test_reset();
    test_backpressure();
    test_random_ready();
    test_clear();
    test_enable();
`ifdef SYNC_FIFO_DRAIN_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
